pe_vector_rebuilder: RTL and testbench

//  Decode side of the 16:4 priority-encoder path. Consumes a stream of encoded

---
 rtl/pe_vector_rebuilder_if.sv | 27 ++
 rtl/pe_vector_rebuilder.sv | 80 ++++++++
 tb/tb_pe_vector_rebuilder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_vector_rebuilder_if.sv
// Beat-in / vector-out bus of the priority-encoder decode path.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface pe_vector_rebuilder_if #(
  parameter int  N_BITS = 16,
  localparam int IDX_W  = $clog2(N_BITS)
);
  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_idx;
  logic              in_none;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_vec;
  logic [IDX_W:0]    out_count;
  logic              out_err;

  modport master (
    output in_valid, in_idx, in_none, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_none, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_err
  );
endinterface

// File: rtl/pe_vector_rebuilder.sv
// Rebuilds a request vector from a stream of highest-bit-first indices and
// emits one registered vector per frame with popcount and ordering-error flag.
module pe_vector_rebuilder #(
  parameter int  N_BITS = 16,
  localparam int IDX_W  = $clog2(N_BITS)
) (
  input logic                  clk,
  input logic                  rst,
  pe_vector_rebuilder_if.slave bus
);
  logic [N_BITS-1:0] acc;
  logic [IDX_W:0]    cnt;
  logic [IDX_W-1:0]  prev_idx;
  logic              first;
  logic              err;

  logic              accept;
  logic              idx_in_range;
  logic [N_BITS-1:0] mask;
  logic              new_bit;
  logic              beat_err;
  logic [N_BITS-1:0] acc_nxt;
  logic [IDX_W:0]    cnt_nxt;
  logic              err_nxt;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // Only reachable when N_BITS is not a power of two.
  assign idx_in_range = ({1'b0, bus.in_idx} < (IDX_W+1)'(N_BITS));

  always_comb begin
    mask     = '0;
    beat_err = 1'b0;
    if (bus.in_none) begin
      beat_err = !(first && bus.in_last);
    end else begin
      if (idx_in_range) mask[bus.in_idx] = 1'b1;
      beat_err = !idx_in_range || (!first && (bus.in_idx >= prev_idx));
    end
    new_bit = |(mask & ~acc);
    acc_nxt = acc | mask;
    cnt_nxt = cnt + {{IDX_W{1'b0}}, new_bit};
    err_nxt = err | beat_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      prev_idx      <= '0;
      first         <= 1'b1;
      err           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_vec   <= '0;
      bus.out_count <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept) begin
        if (!bus.in_none) prev_idx <= bus.in_idx;
        if (bus.in_last) begin
          // Publish the completed frame and restart accumulation in the same edge.
          bus.out_valid <= 1'b1;
          bus.out_vec   <= acc_nxt;
          bus.out_count <= cnt_nxt;
          bus.out_err   <= err_nxt;
          acc           <= '0;
          cnt           <= '0;
          err           <= 1'b0;
          first         <= 1'b1;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          err <= err_nxt;
          if (!bus.in_none) first <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_vector_rebuilder.sv
// Directed and round-trip bench for pe_vector_rebuilder with a frame-level
// reference model and an expected-output queue.
module tb_pe_vector_rebuilder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_vector_rebuilder_if #(.N_BITS(16)) bus ();

  pe_vector_rebuilder #(.N_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [21:0] exp_q[$];
  int          rdy_mode = 0;

  logic [3:0] f_idx[0:31];
  bit         f_none[0:31];
  int         f_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result straight from the rules: OR of named bits, popcount, and
  // error if indices are not strictly descending or a none beat is not alone.
  function automatic logic [21:0] model_frame();
    logic [15:0] v = '0;
    logic        e = 1'b0;
    bit          seen = 0;
    int          prev = 0;
    int          pc = 0;
    for (int i = 0; i < f_n; i++) begin
      if (f_none[i]) begin
        if (seen || i != f_n - 1) e = 1'b1;
      end else begin
        if (seen && int'(f_idx[i]) >= prev) e = 1'b1;
        v[f_idx[i]] = 1'b1;
        prev = int'(f_idx[i]);
        seen = 1;
      end
    end
    for (int b = 0; b < 16; b++) pc += int'(v[b]);
    return {e, 5'(pc), v};
  endfunction

  // Output monitor: checks every handshake against the queue and holds under stall.
  bit          stall_d = 0;
  logic [21:0] held;
  always @(negedge clk) begin
    logic [21:0] e;
    if (rst) begin
      stall_d = 0;
    end else begin
      check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (stall_d) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'({bus.out_err, bus.out_count, bus.out_vec}), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none", {bus.out_err, bus.out_count, bus.out_vec});
        end else begin
          e = exp_q.pop_front();
          check("frame", 32'({bus.out_err, bus.out_count, bus.out_vec}), 32'(e));
        end
      end
      stall_d = bus.out_valid && !bus.out_ready;
      held    = {bus.out_err, bus.out_count, bus.out_vec};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_beat(input logic [3:0] idx, input logic none, input logic last);
    int t;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx;
    bus.in_none  = none;
    bus.in_last  = last;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin
      t++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    exp_q.push_back(model_frame());
    for (int i = 0; i < f_n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      send_beat(f_idx[i], f_none[i], (i == f_n - 1));
    end
  endtask

  task automatic set_frame3(input int n, input int a, input int b, input int c);
    f_n = n;
    f_idx[0] = 4'(a); f_idx[1] = 4'(b); f_idx[2] = 4'(c);
    for (int i = 0; i < 3; i++) f_none[i] = 0;
  endtask

  task automatic encode(input logic [15:0] v);
    f_n = 0;
    if (v == 16'h0) begin
      f_idx[0] = 4'd0; f_none[0] = 1; f_n = 1;
    end else begin
      for (int b = 15; b >= 0; b--) begin
        if (v[b]) begin
          f_idx[f_n] = 4'(b); f_none[f_n] = 0; f_n++;
        end
      end
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] v, input int c, input logic e);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_vec"},   32'(bus.out_vec),   32'(v));
    check({name, "_count"}, 32'(bus.out_count), 32'(c));
    check({name, "_err"},   32'(bus.out_err),   32'(e));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_none = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_vec",   32'(bus.out_vec),   32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);
    check("rst_err",   32'(bus.out_err),   32'd0);
    rst = 1'b0;

    // 1: ordinary descending frame, one-cycle output pulse
    set_frame3(3, 13, 9, 3);
    send_frame(0);
    check_out("t1", 16'h2208, 3, 1'b0);
    @(posedge clk); #1;
    check("t1_pulse_end", 32'(bus.out_valid), 32'd0);

    // 2: sole none beat
    f_n = 1; f_idx[0] = 4'd9; f_none[0] = 1;
    send_frame(0);
    check_out("t2", 16'h0000, 0, 1'b0);

    // 3: ascending order and repeated index
    set_frame3(2, 2, 5, 0);
    send_frame(0);
    check_out("t3a", 16'h0024, 2, 1'b1);
    set_frame3(2, 5, 5, 0);
    send_frame(0);
    check_out("t3b", 16'h0020, 1, 1'b1);
    wait_drain();

    // 4: backpressure with next frame's last beat pending
    bus.out_ready = 1'b0;
    set_frame3(3, 13, 9, 3);
    send_frame(0);
    exp_q.push_back({1'b0, 5'd1, 16'h0080});
    bus.in_valid = 1'b1; bus.in_idx = 4'd7; bus.in_none = 1'b0; bus.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_vec_held", 32'(bus.out_vec), 32'h2208);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_out("t4_next", 16'h0080, 1, 1'b0);
    wait_drain();

    // 5: reset discards a partial frame
    send_beat(4'd15, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    set_frame3(1, 0, 0, 0);
    send_frame(0);
    check_out("t5", 16'h0001, 1, 1'b0);
    wait_drain();

    // 6: random round trip with gaps on both sides
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) v = 16'h0000;
      else if (i == 1) v = 16'hFFFF;
      else v = 16'($urandom_range(0, 65535));
      encode(v);
      send_frame(2);
    end
    wait_drain();
    rdy_mode = 0;
    bus.out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
